// File: rtl/matrix_pkg.sv
// matrix_pkg: shared operation/state encodings and helpers for the matrix front panel
package matrix_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MUL = 3'd3,
    OP_TRN = 3'd4,
    OP_CPY = 3'd5
  } op_t;
  typedef enum logic [2:0] {
    WAIT_A   = 3'd0,
    WAIT_OP  = 3'd1,
    WAIT_B   = 3'd2,
    WAIT_DST = 3'd3,
    ISSUE    = 3'd4
  } cb_state_t;
  localparam logic [2:0] REG_NONE = 3'd0;
  function automatic logic is_unary(logic [2:0] op);
    return op == OP_TRN || op == OP_CPY;
  endfunction
  function automatic logic is_legal_op(logic [2:0] op);
    return op >= OP_ADD && op <= OP_CPY;
  endfunction
endpackage

// File: rtl/command_builder_if.sv
// command_builder_if: panel events in, matrix command and status out
interface command_builder_if;
  logic [2:0] reg_num;
  logic [2:0] op_num;
  logic       clear;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [2:0] cmd_src_a;
  logic [2:0] cmd_src_b;
  logic [2:0] cmd_dst;
  logic       busy;
  logic [2:0] stage;
  logic       err;
  modport master (
    output reg_num, op_num, clear, cmd_ready,
    input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, busy, stage, err
  );
  modport slave (
    input  reg_num, op_num, clear, cmd_ready,
    output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, busy, stage, err
  );
endinterface

// File: rtl/command_builder_idle_timer.sv
// idle_timer: counts idle cycles while run is high and flags the last one
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 12_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic run,
  input  logic restart,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] count_q, count_d;
  always_comb begin
    count_d = (restart || !run) ? '0 : count_q + 1'b1;
    expire = run && count_q == LAST;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/command_builder.sv
// command_builder: assembles panel register/op events into a matrix command with timeout
module command_builder
  import matrix_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 12_000_000
) (
  input logic clk,
  input logic nrst,
  command_builder_if.slave bus
);
  cb_state_t state_q, state_d;
  logic [2:0] src_a_q, src_a_d, op_q, op_d, src_b_q, src_b_d, dst_q, dst_d;
  logic err_q, err_d;
  logic reg_ev, op_ev, op_ok, waiting, clr, accept, expire, timeout, flush;
  always_comb begin
    reg_ev = bus.reg_num != REG_NONE;
    op_ev = bus.op_num != 3'd0;
    op_ok = is_legal_op(bus.op_num);
    waiting = state_q inside {WAIT_OP, WAIT_B, WAIT_DST};
    clr = bus.clear && state_q != ISSUE;
    // in WAIT_OP an op event (legal or not) shadows a simultaneous reg event
    accept = (state_q == WAIT_OP) ? (op_ev ? op_ok : reg_ev) : (state_q != ISSUE && reg_ev);
    timeout = expire && !accept && !clr;
    flush = clr || timeout || (state_q == ISSUE && bus.cmd_ready);
  end
  idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle (
    .clk(clk),
    .nrst(nrst),
    .run(waiting),
    .restart(accept || clr || state_d != state_q),
    .expire(expire)
  );
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state_q <= WAIT_A;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (clr || timeout) state_d = WAIT_A;
    else if (state_q == ISSUE) state_d = bus.cmd_ready ? WAIT_A : ISSUE;
    else if (accept)
      state_d = (state_q == WAIT_A) ? WAIT_OP :
                (state_q == WAIT_OP) ? (!op_ev ? WAIT_OP : is_unary(bus.op_num) ? WAIT_DST : WAIT_B) :
                (state_q == WAIT_B) ? WAIT_DST : ISSUE;
  end
  always_comb begin
    src_a_d = src_a_q;
    op_d = op_q;
    src_b_d = src_b_q;
    dst_d = dst_q;
    err_d = timeout || (state_q == WAIT_OP && op_ev && !op_ok && !clr);
    if (flush) begin
      src_a_d = REG_NONE;
      op_d = 3'd0;
      src_b_d = REG_NONE;
      dst_d = REG_NONE;
    end else if (accept) begin
      if (state_q == WAIT_A || (state_q == WAIT_OP && !op_ev)) src_a_d = bus.reg_num;
      if (state_q == WAIT_OP && op_ev) op_d = bus.op_num;
      if (state_q == WAIT_OP && op_ev && is_unary(bus.op_num)) src_b_d = REG_NONE;
      if (state_q == WAIT_B) src_b_d = bus.reg_num;
      if (state_q == WAIT_DST) dst_d = bus.reg_num;
    end
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      src_a_q <= REG_NONE;
      op_q <= 3'd0;
      src_b_q <= REG_NONE;
      dst_q <= REG_NONE;
      err_q <= 1'b0;
    end else begin
      src_a_q <= src_a_d;
      op_q <= op_d;
      src_b_q <= src_b_d;
      dst_q <= dst_d;
      err_q <= err_d;
    end
  always_comb begin
    bus.cmd_valid = state_q == ISSUE;
    bus.cmd_op = op_q;
    bus.cmd_src_a = src_a_q;
    bus.cmd_src_b = src_b_q;
    bus.cmd_dst = dst_q;
    bus.busy = state_q != WAIT_A;
    bus.stage = state_q;
    bus.err = err_q;
  end
endmodule

// File: tb/tb_command_builder.sv
// tb_command_builder: randomized and directed checks against a token-list reference model
module tb_command_builder;
  localparam int T = 16;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;
  command_builder_if bus();
  command_builder #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .nrst(nrst), .bus(bus));
  int errors = 0;
  int checks = 0;
  int tok[$];
  int idle = 0;
  bit m_err = 0;
  int valid_cnt;
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit m_unary();
    return tok.size() > 1 && (tok[1] == 4 || tok[1] == 5);
  endfunction
  function automatic bit m_done();
    return tok.size() == (m_unary() ? 3 : 4);
  endfunction
  function automatic int m_stage();
    if (m_done()) return 4;
    if (tok.size() == 2 && m_unary()) return 3;
    return tok.size();
  endfunction
  task automatic m_step(int r, int o, bit c, bit rdy);
    int n = tok.size();
    bit got = 0;
    m_err = 0;
    if (m_done()) begin
      if (rdy) tok = {};
      idle = 0;
      return;
    end
    if (c) begin
      tok = {};
      idle = 0;
      return;
    end
    if (n == 1 && o != 0) begin
      if (o <= 5) begin tok.push_back(o); got = 1; end
      else m_err = 1;
    end else if (n == 1 && r != 0) begin
      tok[0] = r;
      got = 1;
    end else if (r != 0) begin
      tok.push_back(r);
      got = 1;
    end
    if (n == 0 || got) idle = 0;
    else if (idle == T - 1) begin
      tok = {};
      idle = 0;
      m_err = 1;
    end else idle++;
  endtask
  task automatic compare();
    check("stage", int'(bus.stage), m_stage());
    check("cmd_valid", int'(bus.cmd_valid), int'(m_done()));
    check("busy", int'(bus.busy), int'(tok.size() != 0));
    check("err", int'(bus.err), int'(m_err));
    check("src_a", int'(bus.cmd_src_a), tok.size() > 0 ? tok[0] : 0);
    check("op", int'(bus.cmd_op), tok.size() > 1 ? tok[1] : 0);
    check("src_b", int'(bus.cmd_src_b), (!m_unary() && tok.size() > 2) ? tok[2] : 0);
    check("dst", int'(bus.cmd_dst), m_done() ? tok[tok.size() - 1] : 0);
  endtask
  task automatic cyc(int r = 0, int o = 0, bit c = 0, bit rdy = 0);
    bus.reg_num = 3'(r);
    bus.op_num = 3'(o);
    bus.clear = c;
    bus.cmd_ready = rdy;
    m_step(r, o, c, rdy);
    @(posedge clk);
    #1;
    compare();
  endtask
  initial begin
    bus.reg_num = 3'd0;
    bus.op_num = 3'd0;
    bus.clear = 1'b0;
    bus.cmd_ready = 1'b0;
    #12;
    compare();
    @(posedge clk);
    #1 nrst = 1'b1;
    cyc(2, 0, 0, 1); cyc(0, 1, 0, 1); cyc(3, 0, 0, 1); cyc(4, 0, 0, 1);
    check("bin_valid", int'(bus.cmd_valid), 1);
    check("bin_fields", {bus.cmd_op, bus.cmd_src_a, bus.cmd_src_b, bus.cmd_dst}, {3'd1, 3'd2, 3'd3, 3'd4});
    cyc(0, 0, 0, 1);
    check("bin_done", {bus.cmd_valid, bus.stage, bus.cmd_op, bus.cmd_dst}, 0);
    valid_cnt = 0;
    cyc(1); cyc(0, 4);
    cyc(2); valid_cnt += bus.cmd_valid;
    cyc(3, 2, 0); valid_cnt += bus.cmd_valid;
    cyc(0, 0, 1); valid_cnt += bus.cmd_valid;
    cyc(4, 0, 0); valid_cnt += bus.cmd_valid;
    cyc(0, 6, 1); valid_cnt += bus.cmd_valid;
    cyc(0, 0, 0); valid_cnt += bus.cmd_valid;
    check("un_fields", {bus.cmd_op, bus.cmd_src_a, bus.cmd_src_b, bus.cmd_dst}, {3'd4, 3'd1, 3'd0, 3'd2});
    cyc(0, 0, 0, 1); valid_cnt += bus.cmd_valid;
    check("un_hold_cycles", valid_cnt, 6);
    cyc(1); cyc(0, 7);
    check("illegal_err", int'(bus.err), 1);
    cyc(3);
    check("illegal_err_once", int'(bus.err), 0);
    cyc(0, 2); cyc(1); cyc(2);
    check("corr_fields", {bus.cmd_src_a, bus.cmd_op}, {3'd3, 3'd2});
    cyc(0, 0, 0, 1);
    cyc(1); cyc(4, 3);
    check("simul", {bus.stage, bus.cmd_src_a, bus.cmd_op}, {3'd2, 3'd1, 3'd3});
    cyc(0, 0, 1);
    cyc(1);
    repeat (15) cyc();
    check("to_not_yet", int'(bus.stage), 1);
    cyc();
    check("to_fire", {bus.stage, bus.err, bus.busy}, {3'd0, 1'b1, 1'b0});
    cyc();
    check("to_err_once", int'(bus.err), 0);
    cyc(1); cyc(0, 1);
    repeat (15) cyc();
    cyc(2);
    check("to_gap15", {bus.stage, bus.err}, {3'd3, 1'b0});
    cyc(0, 0, 1);
    check("clear_dst", {bus.stage, bus.err, bus.cmd_src_a}, 0);
    cyc(1); cyc(0, 5); cyc(3);
    check("rst_pre", int'(bus.cmd_valid), 1);
    #3 nrst = 1'b0;
    #1;
    tok = {};
    idle = 0;
    m_err = 0;
    check("rst_valid", int'(bus.cmd_valid), 0);
    compare();
    @(posedge clk);
    #1 nrst = 1'b1;
    repeat (3000) begin
      if ($urandom_range(0, 39) == 0) repeat (20) cyc();
      else cyc($urandom_range(0, 9) < 3 ? int'($urandom_range(1, 4)) : 0,
               $urandom_range(0, 9) < 2 ? int'($urandom_range(1, 7)) : 0,
               $urandom_range(0, 29) == 0,
               $urandom_range(0, 1) == 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/command_builder.md
# command_builder

Collects one-cycle register-select and operation-select events from the front-panel decoders and assembles them into a complete matrix command: source A, operation, source B (binary ops only) and destination. Sits directly downstream of the register and operation button decoders and upstream of the matrix datapath, which receives commands over a valid/ready handshake. Also provides an inactivity timeout and an error pulse that drive the status display.

## Interface
- TIMEOUT_CYCLES, 12_000_000, consecutive event-free cycles in a mid-entry state before the entry is aborted (1 s at 12 MHz); must be ≥ 2.
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- reg_num  in  3  register event: 1..4 held for exactly one cycle selects register R1..R4; 0 means no event; 5..7 are never driven.
- op_num  in  3  operation event, one-cycle nonzero: 1 ADD, 2 SUB, 3 MUL, 4 TRN (unary), 5 CPY (unary); 6, 7 are illegal; 0 means no event.
- clear  in  1  single-cycle synchronous pulse that abandons the current entry.
- cmd_ready  in  1  datapath accepts the command.
- cmd_valid  out  1  command is complete and held.
- cmd_op  out  3  operation code.
- cmd_src_a, cmd_src_b, cmd_dst  out  3 each  register numbers 1..4; cmd_src_b = 0 for unary ops.
- busy  out  1  high in every state except WAIT_A.
- stage  out  3  current state encoding, for the display.
- err  out  1  one-cycle registered error pulse.

## Operation
- States: WAIT_A, WAIT_OP, WAIT_B, WAIT_DST, ISSUE.
- WAIT_A: a reg event latches src_a and moves to WAIT_OP. op events are ignored.
- WAIT_OP:
  - A legal op event latches the op. Binary ops move to WAIT_B; unary ops force src_b = 0 and move to WAIT_DST.
  - An illegal op (6, 7) pulses err and stays in WAIT_OP.
  - A reg event with no op event replaces src_a and stays in WAIT_OP (user correction).
  - If reg and op events occur in the same cycle, the op wins and the reg event is dropped.
- WAIT_B: a reg event latches src_b and moves to WAIT_DST. op events are ignored.
- WAIT_DST: a reg event latches dst and moves to ISSUE. op events are ignored. src == dst is legal.
- ISSUE:
  - cmd_valid = 1 and all cmd_* fields are held stable.
  - On cmd_valid && cmd_ready, the block returns to WAIT_A and all cmd_* fields clear to 0.
  - clear, reg events and op events are ignored in ISSUE.
- clear, in any state other than ISSUE: go to WAIT_A, zero all latched fields, no err. clear takes priority over a simultaneous event.
- Timeout:
  - The idle counter runs only in WAIT_OP, WAIT_B and WAIT_DST.
  - It zeroes on any accepted event, on any state change and on clear.
  - When the counter equals TIMEOUT_CYCLES-1 and no accepted event occurs that cycle, the block goes to WAIT_A, zeroes all fields and pulses err.
- Reset values: state WAIT_A, every output 0, counter 0.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Event sampled at edge t → new state, latched field and stage are visible after edge t. cmd_valid rises after the edge that samples the dst event.
- err is high for exactly the one cycle after the edge that samples the illegal op or the timeout condition.
- Handshake:
  - cmd_valid stays high until a clock edge that samples cmd_ready = 1.
  - cmd_ready may already be high when cmd_valid rises; acceptance then happens on the next edge, so minimum ISSUE occupancy is 1 cycle.
  - The next WAIT_A event can be accepted on the cycle right after acceptance.
- Timeout abort fires exactly TIMEOUT_CYCLES cycles after entry to the waiting state (or after the last accepted event).
- nrst mid-entry or mid-ISSUE: immediate return to reset values; a pending command is dropped.

## Structure
- Shared package matrix_pkg:
  - op_t enum (OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_TRN=4, OP_CPY=5).
  - cb_state_t enum (WAIT_A=0, WAIT_OP=1, WAIT_B=2, WAIT_DST=3, ISSUE=4).
  - is_unary() function.
  - REG_NONE = 3'd0.
- One sub-module, idle_timer: parameter TIMEOUT_CYCLES; inputs run and restart; outputs a single-cycle expire flag when count == TIMEOUT_CYCLES-1 and run is high. Counter width is $clog2(TIMEOUT_CYCLES).
- FSM, field registers and err register live in command_builder.

## Test plan
- Binary path, TIMEOUT_CYCLES=16: events reg 2, op 1, reg 3, reg 4 on separate cycles, cmd_ready=1 → one cmd_valid cycle with op=1, src_a=2, src_b=3, dst=4; state returns to WAIT_A; all fields 0.
- Unary path plus backpressure: reg 1, op 4, reg 2, then cmd_ready low for 5 cycles → cmd_valid held for 6 cycles with op=4, src_a=1, src_b=0, dst=2 stable; reg/op/clear pulses during the hold are ignored.
- Illegal op and correction: reg 1, op 7, reg 3, op 2 → err pulses once after the op 7 edge; the resulting command has src_a=3, op=2.
- Simultaneous events: in WAIT_OP, reg 4 and op 3 in the same cycle → state WAIT_B, src_a unchanged, op=3.
- Timeout, TIMEOUT_CYCLES=16: reg 1, then no events → exactly 16 cycles later state is WAIT_A, err is high for 1 cycle and busy is 0. With reg 1, op 1 and a gap of 15 cycles before the next reg event, no timeout occurs.
- clear and nrst: clear in WAIT_DST → WAIT_A with no err. nrst asserted during ISSUE → cmd_valid drops immediately and all outputs are 0.
